id_stage: RTL and testbench

Instruction-decode pipeline stage between fetch and execute. Accepts one fetched instruction per cycle over a valid/ready handshake, drives the register-file read addresses combinationally, generates the RV32I immediate, and captures the instruction, PC, both register operands and the immediate into the ID/EX pipeline register. It also stalls fetch on a load-use hazard and drops its contents on a branch flush.

---
 rtl/riscv_pkg.sv | 46 ++++
 rtl/id_stage_if.sv | 41 ++++
 rtl/id_stage_imm_gen.sv | 48 ++++
 rtl/id_stage.sv | 85 ++++++++
 tb/tb_id_stage.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, immediate-format enum and the ID/EX payload layout.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1data;
    logic [XLEN-1:0] rs2data;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } idex_t;

  localparam idex_t IDEX_RST = '{
    inst:    NOP,
    pc:      '0,
    rs1data: '0,
    rs2data: '0,
    imm:     '0,
    illegal: 1'b0
  };

endpackage

// File: rtl/id_stage_if.sv
// Fetch-side, register-file, load-hazard and execute-side signals of the decode stage.
interface id_stage_if #(
  parameter int RFW = 5,
  parameter int DW  = 32,
  parameter int IW  = 32
);
  logic           if_valid;
  logic           if_ready;
  logic [IW-1:0]  if_inst;
  logic [DW-1:0]  if_pc;
  logic [RFW-1:0] rf_reg1;
  logic [RFW-1:0] rf_reg2;
  logic [DW-1:0]  rf_reg1data;
  logic [DW-1:0]  rf_reg2data;
  logic           ex_ld_valid;
  logic [RFW-1:0] ex_ld_rd;
  logic           flush;
  logic           ex_valid;
  logic           ex_ready;
  logic [IW-1:0]  ex_inst;
  logic [DW-1:0]  ex_pc;
  logic [DW-1:0]  ex_rs1data;
  logic [DW-1:0]  ex_rs2data;
  logic [DW-1:0]  ex_imm;
  logic           ex_illegal;

  // slave: the decode stage itself
  modport slave (
    input  if_valid, if_inst, if_pc, rf_reg1data, rf_reg2data,
           ex_ld_valid, ex_ld_rd, flush, ex_ready,
    output if_ready, rf_reg1, rf_reg2, ex_valid, ex_inst, ex_pc,
           ex_rs1data, ex_rs2data, ex_imm, ex_illegal
  );

  modport master (
    output if_valid, if_inst, if_pc, rf_reg1data, rf_reg2data,
           ex_ld_valid, ex_ld_rd, flush, ex_ready,
    input  if_ready, rf_reg1, rf_reg2, ex_valid, ex_inst, ex_pc,
           ex_rs1data, ex_rs2data, ex_imm, ex_illegal
  );
endinterface

// File: rtl/id_stage_imm_gen.sv
// RV32I immediate generator and source-operand usage decode.
// Latency: purely combinational.
// Backpressure: none; output follows the instruction every cycle.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] imm,
  output imm_type_e       imm_type,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic            illegal
);

  logic [6:0] opcode;
  assign opcode = inst[6:0];

  always_comb begin
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    case (opcode)
      OP_R:                       imm_type = IMM_NONE;
      OP_IMM, OP_LOAD, OP_JALR:   imm_type = IMM_I;
      OP_STORE:                   imm_type = IMM_S;
      OP_BRANCH:                  imm_type = IMM_B;
      OP_LUI, OP_AUIPC:           imm_type = IMM_U;
      OP_JAL:                     imm_type = IMM_J;
      default:                    illegal  = 1'b1;
    endcase
  end

  // Unknown opcodes still count as reading rs1 so hazards stay conservative.
  assign uses_rs1 = (imm_type != IMM_U) && (imm_type != IMM_J);
  assign uses_rs2 = (opcode == OP_R) || (imm_type == IMM_S) || (imm_type == IMM_B);

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'h000};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: RF address drive, immediate generation, load-use stall, ID/EX register.
// Latency: one cycle from accept edge to ex_valid/payload.
// Backpressure: if_ready drops on flush, load-use hazard or a stalled full ID/EX register.
module id_stage
  import riscv_pkg::*;
#(
  parameter int RFW = 5,
  parameter int DW  = 32,
  parameter int IW  = 32
) (
  input  logic       clk,
  input  logic       rst,
  id_stage_if.slave  bus
);

  logic [IW-1:0]  inst;
  logic [RFW-1:0] rs1;
  logic [RFW-1:0] rs2;
  logic [DW-1:0]  imm;
  imm_type_e      imm_type_unused;
  logic           uses_rs1;
  logic           uses_rs2;
  logic           illegal;
  logic           hazard;
  logic           accept;
  logic           q_vld;
  idex_t          q;
  idex_t          d;

  assign inst = bus.if_inst;
  assign rs1  = inst[15 +: RFW];
  assign rs2  = inst[20 +: RFW];

  assign bus.rf_reg1 = rs1;
  assign bus.rf_reg2 = rs2;

  imm_gen u_imm_gen (
    .inst     (inst),
    .imm      (imm),
    .imm_type (imm_type_unused),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .illegal  (illegal)
  );

  // A load into x0 produces nothing to wait for.
  assign hazard = bus.ex_ld_valid && (bus.ex_ld_rd != '0) &&
                  ((uses_rs1 && (rs1 == bus.ex_ld_rd)) ||
                   (uses_rs2 && (rs2 == bus.ex_ld_rd)));

  assign bus.if_ready = !rst && !bus.flush && !hazard && (!q_vld || bus.ex_ready);
  assign accept       = bus.if_valid && bus.if_ready;

  assign d = '{
    inst:    inst,
    pc:      bus.if_pc,
    rs1data: bus.rf_reg1data,
    rs2data: bus.rf_reg2data,
    imm:     imm,
    illegal: illegal
  };

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_vld <= 1'b0;
      q     <= IDEX_RST;
    end else if (bus.flush) begin
      q_vld <= 1'b0;
    end else if (accept) begin
      q_vld <= 1'b1;
      q     <= d;
    end else if (bus.ex_ready) begin
      q_vld <= 1'b0;
    end
  end

  assign bus.ex_valid   = q_vld;
  assign bus.ex_inst    = q.inst;
  assign bus.ex_pc      = q.pc;
  assign bus.ex_rs1data = q.rs1data;
  assign bus.ex_rs2data = q.rs2data;
  assign bus.ex_imm     = q.imm;
  assign bus.ex_illegal = q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed and randomized checks of id_stage against a behavioural decode/handshake model.
module tb_id_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if bus ();
  id_stage dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] regs [32];
  assign bus.rf_reg1data = (bus.rf_reg1 == 5'd0) ? 32'd0 : regs[bus.rf_reg1];
  assign bus.rf_reg2data = (bus.rf_reg2 == 5'd0) ? 32'd0 : regs[bus.rf_reg2];

  int total = 0;
  int fails = 0;

  // model of the ID/EX register contents
  bit          m_vld;
  logic [31:0] m_inst, m_pc, m_rs1, m_rs2, m_imm;
  bit          m_ill;

  // currently driven inputs
  bit          c_v, c_ldv, c_fl, c_rdy;
  logic [31:0] c_inst, c_pc;
  logic [4:0]  c_ldrd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_decode(input logic [31:0] i, output logic [31:0] imm,
                                     output bit u1, output bit u2, output bit ill);
    int v;
    imm = 32'd0; u1 = 1'b1; u2 = 1'b0; ill = 1'b0;
    case (i[6:0])
      7'h33: u2 = 1'b1;
      7'h13, 7'h03, 7'h67: imm = 32'($signed(i) >>> 20);
      7'h23: begin
        v = int'($signed(i) >>> 25) * 32 + int'(i[11:7]);
        imm = 32'(v); u2 = 1'b1;
      end
      7'h63: begin
        v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        imm = 32'(v); u2 = 1'b1;
      end
      7'h37, 7'h17: begin imm = i & 32'hFFFF_F000; u1 = 1'b0; end
      7'h6F: begin
        v = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 +
            int'(i[30:21]) * 2;
        imm = 32'(v); u1 = 1'b0;
      end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_vld = 1'b0; m_inst = 32'h0000_0013; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_ill = 1'b0;
  endtask

  task automatic drive(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                       input bit ldv, input logic [4:0] ldrd, input bit fl, input bit rdy);
    c_v = v; c_inst = inst; c_pc = pc; c_ldv = ldv; c_ldrd = ldrd; c_fl = fl; c_rdy = rdy;
    bus.if_valid = v; bus.if_inst = inst; bus.if_pc = pc; bus.ex_ld_valid = ldv;
    bus.ex_ld_rd = ldrd; bus.flush = fl; bus.ex_ready = rdy;
  endtask

  task automatic check_ex(input bit all);
    check("ex_valid", {31'd0, bus.ex_valid}, {31'd0, m_vld});
    if (m_vld || all) begin
      check("ex_inst", bus.ex_inst, m_inst);
      check("ex_pc", bus.ex_pc, m_pc);
      check("ex_rs1data", bus.ex_rs1data, m_rs1);
      check("ex_rs2data", bus.ex_rs2data, m_rs2);
      check("ex_imm", bus.ex_imm, m_imm);
      check("ex_illegal", {31'd0, bus.ex_illegal}, {31'd0, m_ill});
    end
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model, check registers.
  task automatic step();
    logic [31:0] imm;
    bit u1, u2, ill, hz, rdy;
    logic [4:0] a1, a2;
    @(negedge clk);
    a1 = c_inst[19:15];
    a2 = c_inst[24:20];
    ref_decode(c_inst, imm, u1, u2, ill);
    hz  = c_ldv && (c_ldrd != 0) && ((u1 && a1 == c_ldrd) || (u2 && a2 == c_ldrd));
    rdy = !c_fl && !hz && (!m_vld || c_rdy);
    check("if_ready", {31'd0, bus.if_ready}, {31'd0, rdy});
    check("rf_reg1", {27'd0, bus.rf_reg1}, {27'd0, a1});
    check("rf_reg2", {27'd0, bus.rf_reg2}, {27'd0, a2});
    if (c_fl) m_vld = 1'b0;
    else if (c_v && rdy) begin
      m_vld = 1'b1; m_inst = c_inst; m_pc = c_pc; m_imm = imm; m_ill = ill;
      m_rs1 = (a1 == 0) ? 32'd0 : regs[a1];
      m_rs2 = (a2 == 0) ? 32'd0 : regs[a2];
    end else if (c_rdy) m_vld = 1'b0;
    @(posedge clk);
    #1;
    check_ex(1'b0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [12];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h0B, 7'h00};
    r = $urandom();
    return {r[31:7], ops[$urandom_range(0, 11)]};
  endfunction

  logic [31:0] seq_inst [4];
  logic [31:0] seq_imm  [4];

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom();
    regs[2] = 32'd5;
    seq_inst = '{32'h0051_2423, 32'hFE20_8EE3, 32'h1234_51B7, 32'h0080_00EF};
    seq_imm  = '{32'h0000_0008, 32'hFFFF_FFFC, 32'h1234_5000, 32'h0000_0008};

    rst = 1'b1;
    drive(0, 32'h0000_0013, 0, 0, 0, 0, 1);
    model_reset();
    #2;
    check("rst_if_ready", {31'd0, bus.if_ready}, 32'd0);
    check_ex(1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    // addi x1,x2,-1
    drive(1, 32'hFFF1_0093, 32'h100, 0, 0, 0, 1);
    step();
    check("addi_rs1data", bus.ex_rs1data, 32'd5);
    check("addi_imm", bus.ex_imm, 32'hFFFF_FFFF);

    // back-to-back sw / beq / lui / jal
    for (int k = 0; k < 4; k++) begin
      drive(1, seq_inst[k], 32'h104 + 32'(4 * k), 0, 0, 0, 1);
      step();
      check("seq_imm", bus.ex_imm, seq_imm[k]);
    end

    // load-use on rs1 of add x4,x3,x5, then release
    drive(1, 32'h0051_8233, 32'h200, 1, 5'd3, 0, 1);
    step();
    check("hazard_bubble", {31'd0, bus.ex_valid}, 32'd0);
    drive(1, 32'h0051_8233, 32'h200, 0, 5'd3, 0, 1);
    step();
    check("hazard_release", bus.ex_inst, 32'h0051_8233);
    drive(1, 32'h0051_8233, 32'h204, 1, 5'd0, 0, 1);
    step();
    drive(1, 32'h0001_81B7, 32'h208, 1, 5'd3, 0, 1);
    step();
    check("lui_no_stall", bus.ex_inst, 32'h0001_81B7);

    // downstream stall for three cycles
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h0051_2423, 32'h20C, 0, 0, 0, 0);
      step();
      check("stall_hold", bus.ex_inst, 32'h0001_81B7);
    end
    drive(1, 32'h0051_2423, 32'h20C, 0, 0, 0, 1);
    step();
    check("stall_release", bus.ex_inst, 32'h0051_2423);

    drive(1, 32'hFE20_8EE3, 32'h300, 0, 0, 1, 1);
    step();
    check("flush_kill", {31'd0, bus.ex_valid}, 32'd0);

    drive(1, 32'hFFFF_FFFF, 32'h400, 0, 0, 0, 1);
    step();
    check("illegal_flag", {31'd0, bus.ex_illegal}, 32'd1);

    // asynchronous reset while a live instruction sits in ID/EX
    drive(1, 32'hFFF1_0093, 32'h404, 0, 0, 0, 0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_if_ready", {31'd0, bus.if_ready}, 32'd0);
    check_ex(1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ri;
      logic [4:0] rd;
      ri = rand_inst();
      rd = ($urandom_range(0, 1) == 1) ? ri[19:15] : 5'($urandom_range(0, 31));
      drive($urandom_range(0, 9) < 8, ri, $urandom(), $urandom_range(0, 9) < 4, rd,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
      step();
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
